// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the hardwired CPU control unit:
// opcodes, instruction classes, FSM state codes and the strobe bundle.
package cpu_ctrl_pkg;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpShr  = 5'b00101;
  localparam logic [4:0] OpShra = 5'b00110;
  localparam logic [4:0] OpShl  = 5'b00111;
  localparam logic [4:0] OpRor  = 5'b01000;
  localparam logic [4:0] OpRol  = 5'b01001;
  localparam logic [4:0] OpAnd  = 5'b01010;
  localparam logic [4:0] OpOr   = 5'b01011;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] OpAndi = 5'b01101;
  localparam logic [4:0] OpOri  = 5'b01110;
  localparam logic [4:0] OpMul  = 5'b01111;
  localparam logic [4:0] OpDiv  = 5'b10000;
  localparam logic [4:0] OpNeg  = 5'b10001;
  localparam logic [4:0] OpNot  = 5'b10010;
  localparam logic [4:0] OpBr   = 5'b10011;
  localparam logic [4:0] OpJr   = 5'b10100;
  localparam logic [4:0] OpJal  = 5'b10101;
  localparam logic [4:0] OpIn   = 5'b10110;
  localparam logic [4:0] OpOut  = 5'b10111;
  localparam logic [4:0] OpMfhi = 5'b11000;
  localparam logic [4:0] OpMflo = 5'b11001;
  localparam logic [4:0] OpNop  = 5'b11010;
  localparam logic [4:0] OpHalt = 5'b11011;

  typedef enum logic [3:0] {
    ClsAlu3, ClsAluI, ClsMulDiv, ClsUnary, ClsLd, ClsLdi, ClsSt, ClsBr,
    ClsJr, ClsJal, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt
  } op_class_e;

  localparam logic [3:0] StRst = 4'd0;
  localparam logic [3:0] StF0  = 4'd1;
  localparam logic [3:0] StFw  = 4'd2;
  localparam logic [3:0] StF1  = 4'd3;
  localparam logic [3:0] StF2  = 4'd4;
  localparam logic [3:0] StE0  = 4'd5;
  localparam logic [3:0] StE1  = 4'd6;
  localparam logic [3:0] StE2  = 4'd7;
  localparam logic [3:0] StE3  = 4'd8;
  localparam logic [3:0] StE4  = 4'd9;
  localparam logic [3:0] StE5  = 4'd10;
  localparam logic [3:0] StE6  = 4'd11;
  localparam logic [3:0] StE7  = 4'd12;
  localparam logic [3:0] StE8  = 4'd13;
  localparam logic [3:0] StHlt = 4'd14;

  typedef struct packed {
    logic pc_out;
    logic mdr_out;
    logic zhigh_out;
    logic zlow_out;
    logic hi_out;
    logic lo_out;
    logic inport_out;
    logic c_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic zhi_in;
    logic zlo_in;
    logic hi_in;
    logic lo_in;
    logic con_in;
    logic out_port_en;
    logic read;
    logic ram_wr;
    logic inc_pc;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic run;
    logic illegal;
  } ctrl_t;

endpackage

// File: rtl/cu_opclass_decode.sv
// Maps the 5-bit opcode onto its execute class; undefined opcodes decode as
// NOP with the illegal flag raised.
module cu_opclass_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output op_class_e  op_class,
  output logic       illegal
);

  always_comb begin
    op_class = ClsNop;
    illegal  = 1'b0;
    case (opcode)
      OpAdd, OpSub, OpShr, OpShra, OpShl, OpRor, OpRol, OpAnd, OpOr: op_class = ClsAlu3;
      OpAddi, OpAndi, OpOri: op_class = ClsAluI;
      OpMul, OpDiv:          op_class = ClsMulDiv;
      OpNeg, OpNot:          op_class = ClsUnary;
      OpLd:                  op_class = ClsLd;
      OpLdi:                 op_class = ClsLdi;
      OpSt:                  op_class = ClsSt;
      OpBr:                  op_class = ClsBr;
      OpJr:                  op_class = ClsJr;
      OpJal:                 op_class = ClsJal;
      OpIn:                  op_class = ClsIn;
      OpOut:                 op_class = ClsOut;
      OpMfhi:                op_class = ClsMfhi;
      OpMflo:                op_class = ClsMflo;
      OpNop:                 op_class = ClsNop;
      OpHalt:                op_class = ClsHalt;
      default:               illegal  = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch / per-class execute T-state machine that
// drives every datapath strobe from the registered state and the loaded IR.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        stop,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic        PCout,
  output logic        MDRout,
  output logic        ZHighout,
  output logic        ZLowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        ZHIin,
  output logic        ZLOin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        enable_outPort,
  output logic        Read,
  output logic        RAM_wr_enable,
  output logic        IncPC,
  output logic        GRA,
  output logic        GRB,
  output logic        GRC,
  output logic        R_in,
  output logic        R_out,
  output logic        Baout,
  output logic        run,
  output logic        illegal
);

  localparam logic [1:0] WaitInit = (MEM_LAT == 0) ? 2'd0 : 2'(MEM_LAT - 1);

  logic [3:0] state_q, state_d, eff_state;
  logic [1:0] wait_q, wait_d;
  logic       stop_q, stop_d;
  logic       last;
  op_class_e  op_class;
  logic       op_illegal;
  ctrl_t      ctrl;
  logic       unused_ir;

  assign unused_ir = ^ir[26:0];

  cu_opclass_decode u_decode (
    .opcode   (ir[31:27]),
    .op_class (op_class),
    .illegal  (op_illegal)
  );

  // IR only becomes valid in E0, so NOP and HALT resolve there: E0 then acts
  // exactly like the F0 (or HLT) that the instruction would have jumped to.
  always_comb begin
    eff_state = state_q;
    if (state_q == StE0 && !op_illegal) begin
      if (op_class == ClsHalt)     eff_state = StHlt;
      else if (op_class == ClsNop) eff_state = stop_q ? StHlt : StF0;
    end
  end

  always_comb begin
    state_d = eff_state;
    wait_d  = wait_q;
    last    = 1'b0;
    case (eff_state)
      StRst: state_d = StF0;
      StF0: begin
        if (MEM_LAT == 0) state_d = StF1;
        else begin
          state_d = StFw;
          wait_d  = WaitInit;
        end
      end
      StFw: begin
        if (wait_q == 2'd0) state_d = StF1;
        else                wait_d  = wait_q - 2'd1;
      end
      StF1: state_d = StF2;
      StF2: state_d = StE0;
      StE0: begin
        if (op_illegal) last = 1'b1;
        else begin
          case (op_class)
            ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo: last = 1'b1;
            default: state_d = StE1;
          endcase
        end
      end
      StE1: begin
        case (op_class)
          ClsUnary, ClsJal: last = 1'b1;
          default: state_d = StE2;
        endcase
      end
      StE2: begin
        case (op_class)
          ClsAlu3, ClsAluI, ClsLdi: last = 1'b1;
          ClsLd: begin
            if (MEM_LAT == 0) state_d = StE4;
            else begin
              state_d = StE3;
              wait_d  = WaitInit;
            end
          end
          default: state_d = StE3;
        endcase
      end
      StE3: begin
        case (op_class)
          ClsLd: begin
            if (wait_q == 2'd0) state_d = StE4;
            else                wait_d  = wait_q - 2'd1;
          end
          ClsSt:   state_d = StE4;
          default: last = 1'b1;
        endcase
      end
      StE4: begin
        if (op_class == ClsLd) state_d = StE5;
        else                   last = 1'b1;
      end
      StE5:             last = 1'b1;
      StHlt:            state_d = StHlt;
      StE6, StE7, StE8: state_d = StF0;
      default:          state_d = StF0;
    endcase
    if (last) state_d = (stop_q || stop) ? StHlt : StF0;
  end

  assign stop_d = stop_q | (stop & (state_q != StRst));

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StRst;
      wait_q  <= 2'd0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stop_q  <= stop_d;
    end
  end

  always_comb begin
    ctrl     = '0;
    ctrl.run = (eff_state != StRst) && (eff_state != StHlt);
    case (eff_state)
      StF0: begin ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; end
      StFw: ctrl.read = 1'b1;
      StF1: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
      StF2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; end
      StE0: begin
        if (op_illegal) ctrl.illegal = 1'b1;
        else begin
          case (op_class)
            ClsAlu3, ClsAluI: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            ClsMulDiv: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            ClsUnary:  begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zlo_in = 1'b1; end
            ClsLd, ClsLdi, ClsSt: begin
              ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
            end
            ClsBr:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
            ClsJr:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            ClsJal:  begin ctrl.pc_out = 1'b1; ctrl.grb = 1'b1; ctrl.r_in = 1'b1; end
            ClsIn:   begin ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            ClsOut:  begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_en = 1'b1; end
            ClsMfhi: begin ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            ClsMflo: begin ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            default: ;
          endcase
        end
      end
      StE1: begin
        case (op_class)
          ClsAlu3:   begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.zlo_in = 1'b1; end
          ClsAluI, ClsLd, ClsLdi, ClsSt: begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; end
          ClsMulDiv: begin
            ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.zhi_in = 1'b1; ctrl.zlo_in = 1'b1;
          end
          ClsUnary: begin ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
          ClsBr:    begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
          ClsJal:   begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
          default: ;
        endcase
      end
      StE2: begin
        case (op_class)
          ClsAlu3, ClsAluI, ClsLdi: begin
            ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
          end
          ClsMulDiv:    begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; end
          ClsLd, ClsSt: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; end
          ClsBr:        begin ctrl.c_out = 1'b1; ctrl.zlo_in = 1'b1; end
          default: ;
        endcase
      end
      StE3: begin
        case (op_class)
          ClsMulDiv: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
          ClsBr:     begin ctrl.zlow_out = con_ff; ctrl.pc_in = con_ff; end
          ClsLd:     ctrl.read = 1'b1;
          ClsSt:     begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
          default: ;
        endcase
      end
      StE4: begin
        case (op_class)
          ClsLd:   begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
          ClsSt:   ctrl.ram_wr = 1'b1;
          default: ;
        endcase
      end
      StE5: begin
        if (op_class == ClsLd) begin
          ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign PCout          = ctrl.pc_out;
  assign MDRout         = ctrl.mdr_out;
  assign ZHighout       = ctrl.zhigh_out;
  assign ZLowout        = ctrl.zlow_out;
  assign HIout          = ctrl.hi_out;
  assign LOout          = ctrl.lo_out;
  assign InPortout      = ctrl.inport_out;
  assign Cout           = ctrl.c_out;
  assign PCin           = ctrl.pc_in;
  assign IRin           = ctrl.ir_in;
  assign MARin          = ctrl.mar_in;
  assign MDRin          = ctrl.mdr_in;
  assign Yin            = ctrl.y_in;
  assign ZHIin          = ctrl.zhi_in;
  assign ZLOin          = ctrl.zlo_in;
  assign HIin           = ctrl.hi_in;
  assign LOin           = ctrl.lo_in;
  assign CONin          = ctrl.con_in;
  assign enable_outPort = ctrl.out_port_en;
  assign Read           = ctrl.read;
  assign RAM_wr_enable  = ctrl.ram_wr;
  assign IncPC          = ctrl.inc_pc;
  assign GRA            = ctrl.gra;
  assign GRB            = ctrl.grb;
  assign GRC            = ctrl.grc;
  assign R_in           = ctrl.r_in;
  assign R_out          = ctrl.r_out;
  assign Baout          = ctrl.ba_out;
  assign run            = ctrl.run;
  assign illegal        = ctrl.illegal;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a per-instruction step-list model feeds a queue
// of expected strobe vectors that one loop checks every cycle.
module tb_control_sequencer;

  localparam int unsigned M = 1;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic stop = 1'b0;
  logic con_ff = 1'b0;
  logic [31:0] ir = 32'h0;

  logic PCout, MDRout, ZHighout, ZLowout, HIout, LOout, InPortout, Cout;
  logic PCin, IRin, MARin, MDRin, Yin, ZHIin, ZLOin, HIin, LOin, CONin, enable_outPort;
  logic Read, RAM_wr_enable, IncPC, GRA, GRB, GRC, R_in, R_out, Baout, run, illegal;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_LAT(M)) dut (
    .clk(clk), .clr(clr), .stop(stop), .ir(ir), .con_ff(con_ff),
    .PCout(PCout), .MDRout(MDRout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .ZHIin(ZHIin), .ZLOin(ZLOin), .HIin(HIin), .LOin(LOin), .CONin(CONin),
    .enable_outPort(enable_outPort), .Read(Read), .RAM_wr_enable(RAM_wr_enable),
    .IncPC(IncPC), .GRA(GRA), .GRB(GRB), .GRC(GRC), .R_in(R_in), .R_out(R_out),
    .Baout(Baout), .run(run), .illegal(illegal)
  );

  logic [29:0] dut_vec;
  assign dut_vec = {illegal, run, Baout, R_out, R_in, GRC, GRB, GRA, IncPC, RAM_wr_enable,
                    Read, enable_outPort, CONin, LOin, HIin, ZLOin, ZHIin, Yin, MDRin, MARin,
                    IRin, PCin, Cout, InPortout, LOout, HIout, ZLowout, ZHighout, MDRout, PCout};

  localparam logic [29:0] SPcOut = 30'd1 << 0,  SMdrOut = 30'd1 << 1,  SZhOut = 30'd1 << 2;
  localparam logic [29:0] SZlOut = 30'd1 << 3,  SHiOut  = 30'd1 << 4,  SLoOut = 30'd1 << 5;
  localparam logic [29:0] SInOut = 30'd1 << 6,  SCOut   = 30'd1 << 7,  SPcIn  = 30'd1 << 8;
  localparam logic [29:0] SIrIn  = 30'd1 << 9,  SMarIn  = 30'd1 << 10, SMdrIn = 30'd1 << 11;
  localparam logic [29:0] SYIn   = 30'd1 << 12, SZhIn   = 30'd1 << 13, SZlIn  = 30'd1 << 14;
  localparam logic [29:0] SHiIn  = 30'd1 << 15, SLoIn   = 30'd1 << 16, SConIn = 30'd1 << 17;
  localparam logic [29:0] SOutEn = 30'd1 << 18, SRead   = 30'd1 << 19, SWr    = 30'd1 << 20;
  localparam logic [29:0] SInc   = 30'd1 << 21, SGra    = 30'd1 << 22, SGrb   = 30'd1 << 23;
  localparam logic [29:0] SGrc   = 30'd1 << 24, SRin    = 30'd1 << 25, SRout  = 30'd1 << 26;
  localparam logic [29:0] SBa    = 30'd1 << 27, SRun    = 30'd1 << 28, SIll   = 30'd1 << 29;

  typedef struct {
    logic [29:0] vec;
    logic [31:0] ir;
    logic        con;
    logic        stop;
    string       name;
  } step_t;

  step_t       exp_q[$];
  int          f0_q[$];
  logic [31:0] last_ir = 32'h0;
  logic        last_con = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  int          ill_cnt = 0;

  task automatic chk_vec(input string name, input logic [29:0] got, input logic [29:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Step list of one instruction, straight from the fetch and execute tables.
  task automatic push_instr(input logic [4:0] op, input logic con, input int stop_at);
    logic [29:0] s[$];
    logic [31:0] new_ir;
    step_t       e;
    new_ir = {op, 27'($urandom)};
    s.push_back(SPcOut | SMarIn | SInc);
    for (int i = 0; i < int'(M); i++) s.push_back(SRead);
    s.push_back(SRead | SMdrIn);
    s.push_back(SMdrOut | SIrIn);
    if (op inside {[5'd3:5'd11]}) begin
      s.push_back(SGrb | SRout | SYIn);
      s.push_back(SGrc | SRout | SZlIn);
      s.push_back(SZlOut | SGra | SRin);
    end else if (op inside {[5'd12:5'd14]}) begin
      s.push_back(SGrb | SRout | SYIn);
      s.push_back(SCOut | SZlIn);
      s.push_back(SZlOut | SGra | SRin);
    end else if (op inside {5'd15, 5'd16}) begin
      s.push_back(SGra | SRout | SYIn);
      s.push_back(SGrb | SRout | SZhIn | SZlIn);
      s.push_back(SZlOut | SLoIn);
      s.push_back(SZhOut | SHiIn);
    end else if (op inside {5'd17, 5'd18}) begin
      s.push_back(SGrb | SRout | SZlIn);
      s.push_back(SZlOut | SGra | SRin);
    end else if (op inside {5'd0, 5'd1, 5'd2}) begin
      s.push_back(SGrb | SRout | SBa | SYIn);
      s.push_back(SCOut | SZlIn);
      if (op == 5'd1) s.push_back(SZlOut | SGra | SRin);
      else s.push_back(SZlOut | SMarIn);
      if (op == 5'd0) begin
        for (int i = 0; i < int'(M); i++) s.push_back(SRead);
        s.push_back(SRead | SMdrIn);
        s.push_back(SMdrOut | SGra | SRin);
      end else if (op == 5'd2) begin
        s.push_back(SGra | SRout | SMdrIn);
        s.push_back(SWr);
      end
    end else if (op == 5'd19) begin
      s.push_back(SGra | SRout | SConIn);
      s.push_back(SPcOut | SYIn);
      s.push_back(SCOut | SZlIn);
      s.push_back(con ? (SZlOut | SPcIn) : 30'd0);
    end else if (op == 5'd20) s.push_back(SGra | SRout | SPcIn);
    else if (op == 5'd21) begin
      s.push_back(SPcOut | SGrb | SRin);
      s.push_back(SGra | SRout | SPcIn);
    end else if (op == 5'd22) s.push_back(SInOut | SGra | SRin);
    else if (op == 5'd23) s.push_back(SGra | SRout | SOutEn);
    else if (op == 5'd24) s.push_back(SHiOut | SGra | SRin);
    else if (op == 5'd25) s.push_back(SLoOut | SGra | SRin);
    else if (op inside {5'd26, 5'd27}) begin
    end else s.push_back(SIll);
    for (int i = 0; i < s.size(); i++) begin
      e.vec  = s[i] | SRun;
      // The opcode changes on the second fetch cycle, never while E0 may still read it.
      e.ir   = (i == 0) ? last_ir : new_ir;
      e.con  = (i == 0) ? last_con : con;
      e.stop = (i == stop_at);
      e.name = $sformatf("op%05b.step%0d", op, i);
      exp_q.push_back(e);
    end
    last_ir  = new_ir;
    last_con = con;
  endtask

  task automatic push_idle(input int n);
    step_t e;
    for (int i = 0; i < n; i++) begin
      e.vec  = 30'd0;
      e.ir   = last_ir;
      e.con  = last_con;
      e.stop = 1'b0;
      e.name = $sformatf("halted%0d", i);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_queue(input string tag);
    int    cyc;
    step_t e;
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      e      = exp_q.pop_front();
      ir     = e.ir;
      con_ff = e.con;
      stop   = e.stop;
      @(negedge clk);
      cyc++;
      chk_vec({tag, ".", e.name}, dut_vec, e.vec);
      if (cyc == 1) chk_vec({tag, ".first_f0"}, dut_vec, SPcOut | SMarIn | SInc | SRun);
      n_cmp++;
      if ($countones(dut_vec[7:0]) > 1) begin
        n_bad++;
        $display("FAIL %s.bus_sources cyc=%0d: got %b required at most one", tag, cyc,
                 dut_vec[7:0]);
      end
      if (PCout && MARin && IncPC) f0_q.push_back(cyc);
      if (RAM_wr_enable) wr_cnt++;
      if (illegal) ill_cnt++;
    end
  endtask

  task automatic do_reset(input logic stop_val, input string tag);
    @(posedge clk);
    #1;
    clr  = 1'b0;
    stop = stop_val;
    @(posedge clk);
    @(negedge clk);
    chk_vec({tag, ".reset_c1"}, dut_vec, 30'd0);
    @(posedge clk);
    @(negedge clk);
    chk_vec({tag, ".reset_c2"}, dut_vec, 30'd0);
    clr = 1'b1;
  endtask

  initial begin
    do_reset(1'b0, "seg1");
    push_instr(5'b00011, 1'b0, -1);   // add
    push_instr(5'b00000, 1'b0, -1);   // ld
    push_instr(5'b00010, 1'b0, -1);   // st
    push_instr(5'b00001, 1'b0, -1);   // ldi
    push_instr(5'b01100, 1'b0, -1);   // addi
    push_instr(5'b01111, 1'b0, -1);   // mul
    push_instr(5'b10001, 1'b0, -1);   // neg
    push_instr(5'b10011, 1'b0, -1);   // br, not taken
    push_instr(5'b10011, 1'b1, -1);   // br, taken
    push_instr(5'b10100, 1'b0, -1);   // jr
    push_instr(5'b10101, 1'b0, -1);   // jal
    push_instr(5'b10110, 1'b0, -1);   // in
    push_instr(5'b10111, 1'b0, -1);   // out
    push_instr(5'b11000, 1'b0, -1);   // mfhi
    push_instr(5'b11001, 1'b0, -1);   // mflo
    push_instr(5'b11010, 1'b0, -1);   // nop
    push_instr(5'b01011, 1'b0, -1);   // or
    push_instr(5'b10000, 1'b0, 5);    // div, stop pulsed in its second execute step
    push_idle(20);
    run_queue("seg1");

    if (f0_q.size() >= 4) begin
      chk_int("f0_at_cycle1", f0_q[0], 1);
      chk_int("f0_after_add", f0_q[1], 8);
      chk_int("f0_after_ld", f0_q[2], 18);
      chk_int("f0_after_st", f0_q[3], 27);
    end else chk_int("f0_count", f0_q.size(), 4);
    chk_int("ram_wr_cycles", wr_cnt, 1);

    // Leave HLT, abort a ST before its write, then illegal and halt.
    do_reset(1'b1, "seg2");
    push_instr(5'b00010, 1'b0, -1);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    run_queue("seg2");
    do_reset(1'b1, "seg3");
    push_instr(5'b11111, 1'b0, -1);   // undefined
    push_instr(5'b11011, 1'b0, -1);   // halt
    push_idle(5);
    run_queue("seg3");
    chk_int("ram_wr_cycles_total", wr_cnt, 1);
    chk_int("illegal_cycles", ill_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
